// File: rtl/fp32_to_int32_seq.sv
// IEEE-754 binary32 to signed 32-bit integer converter, round toward zero,
// with saturation, exception flags and a STEP-bit-per-cycle iterative shifter.
module fp32_to_int32_seq #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PACK  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [4:0]  STEP_W  = 5'(STEP);
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  flags_q, flags_d;

    logic        in_s;
    logic [7:0]  in_e;
    logic [22:0] in_m;
    logic [4:0]  k_c;
    logic        lost_c;

    assign in_s = in_data[31];
    assign in_e = in_data[30:23];
    assign in_m = in_data[22:0];

    assign out_data  = data_q;
    assign out_flags = flags_q;

    // Shift amount this cycle and OR of the bits about to fall off the bottom.
    always_comb begin
        k_c    = (cnt_q < STEP_W) ? cnt_q : STEP_W;
        lost_c = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (5'(i) < k_c) begin
                lost_c = lost_c | mag_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        sign_d    = sign_q;
        data_d    = data_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d = in_s;
                    if (in_e == 8'd255) begin
                        if (in_m != '0) begin
                            data_d  = INT_MAX;
                            flags_d = 3'b100;
                        end else begin
                            data_d  = in_s ? INT_MIN : INT_MAX;
                            flags_d = 3'b010;
                        end
                        state_d = OUT;
                    end else if (in_e >= 8'd158) begin
                        if (in_e == 8'd158 && in_s && in_m == '0) begin
                            data_d  = INT_MIN;
                            flags_d = 3'b000;
                        end else begin
                            data_d  = in_s ? INT_MIN : INT_MAX;
                            flags_d = 3'b010;
                        end
                        state_d = OUT;
                    end else if (in_e < 8'd127) begin
                        data_d  = '0;
                        flags_d = {2'b00, (in_e != '0) || (in_m != '0)};
                        state_d = OUT;
                    end else begin
                        mag_d    = {1'b1, in_m, 8'b0};
                        cnt_d    = 5'(8'd158 - in_e);
                        sticky_d = 1'b0;
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mag_d    = mag_q >> k_c;
                sticky_d = sticky_q | lost_c;
                cnt_d    = cnt_q - k_c;
                if (cnt_d == '0) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                data_d  = sign_q ? (~mag_q + 32'd1) : mag_q;
                flags_d = {2'b00, sticky_q};
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            data_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Directed plus randomised bench for fp32_to_int32_seq with a scoreboard queue
// of expected results and latencies.
module tb_fp32_to_int32_seq;

    localparam int unsigned STEP = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  f;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    fp32_to_int32_seq #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: scale the 24-bit significand directly by 2^(E-150).
    function automatic void model(input logic [31:0] op, output logic [31:0] d,
                                  output logic [2:0] f, output int lat);
        logic        s;
        int          e;
        logic [22:0] m;
        logic [63:0] full;
        logic [63:0] mag;
        logic        inex;
        s   = op[31];
        e   = int'(op[30:23]);
        m   = op[22:0];
        lat = 1;
        if (e == 255) begin
            d = (m != 0) ? 32'h7FFFFFFF : (s ? 32'h80000000 : 32'h7FFFFFFF);
            f = (m != 0) ? 3'b100 : 3'b010;
        end else if (e >= 158) begin
            if (e == 158 && s && m == 0) begin
                d = 32'h80000000;
                f = 3'b000;
            end else begin
                d = s ? 32'h80000000 : 32'h7FFFFFFF;
                f = 3'b010;
            end
        end else if (e < 127) begin
            d = 32'h0;
            f = {2'b00, (e != 0) || (m != 0)};
        end else begin
            full = {40'd0, 1'b1, m};
            if (e >= 150) begin
                mag  = full << (e - 150);
                inex = 1'b0;
            end else begin
                mag  = full >> (150 - e);
                inex = (full & ((64'd1 << (150 - e)) - 64'd1)) != 64'd0;
            end
            d   = s ? 32'(-mag) : mag[31:0];
            f   = {2'b00, inex};
            lat = 2 + (158 - e + int'(STEP) - 1) / int'(STEP);
        end
    endfunction

    task automatic convert(input logic [31:0] op, input logic [31:0] ed, input logic [2:0] ef,
                           input int lat, input int hold, input string tag);
        exp_t e;
        int   j;
        e.d = ed;
        e.f = ef;
        e.lat = lat;
        sbq.push_back(e);
        @(negedge clk);
        chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = op;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        j = 0;
        while (out_valid !== 1'b1 && j < 200) begin
            @(posedge clk);
            #1;
            j++;
        end
        e = sbq.pop_front();
        chk({tag, " data"}, 64'(out_data), 64'(e.d));
        chk({tag, " flags"}, 64'(out_flags), 64'(e.f));
        chk({tag, " latency"}, 64'(j + 1), 64'(e.lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold_data"}, 64'(out_data), 64'(e.d));
            chk({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " post_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] op, ed;
        logic [2:0]  ef;
        int          lat;
        int          j;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_flags", 64'(out_flags), 64'd0);
        rst = 1'b0;

        convert(32'h3F800000, 32'h00000001, 3'b000, 10, 0, "one");
        convert(32'hC0490FDB, 32'hFFFFFFFD, 3'b001, 10, 0, "neg_pi");
        convert(32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 3, 0, "max_normal");
        convert(32'h4F000000, 32'h7FFFFFFF, 3'b010, 1, 0, "pos_2p31");
        convert(32'hCF000000, 32'h80000000, 3'b000, 1, 0, "neg_2p31");
        convert(32'hCF000001, 32'h80000000, 3'b010, 1, 0, "neg_ovf");
        convert(32'hFF800000, 32'h80000000, 3'b010, 1, 0, "neg_inf");
        convert(32'h7F800000, 32'h7FFFFFFF, 3'b010, 1, 0, "pos_inf");
        convert(32'h7FC00000, 32'h7FFFFFFF, 3'b100, 1, 0, "nan");
        convert(32'h3F000000, 32'h00000000, 3'b001, 1, 0, "half");
        convert(32'h80000000, 32'h00000000, 3'b000, 1, 0, "neg_zero");
        convert(32'h00000001, 32'h00000000, 3'b001, 1, 0, "denormal");
        convert(32'h42F60000, 32'h0000007B, 3'b000, 9, 5, "backpressure");

        // Abort a conversion part-way through its shift phase.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        j = 0;
        while (j < 15) begin
            @(posedge clk);
            #1;
            chk("abort no_output", 64'(out_valid), 64'd0);
            j += 5;
        end
        convert(32'h40000000, 32'h00000002, 3'b000, 10, 0, "after_abort");

        for (int i = 0; i < 16; i++) begin
            op = $urandom;
            if (i < 12) begin
                op[30:23] = 8'($urandom_range(127, 157));
            end
            model(op, ed, ef, lat);
            convert(op, ed, ef, lat, (i % 4 == 3) ? 2 : 0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
